// File: rtl/hash_search_ctrl.sv
// hash_search_ctrl
//   Sequencing controller for the micro_ucr_hash datapath. It accepts a search
//   job (96-bit block + 8-bit target), issues one nonce per cycle to a hash core
//   with CORE_LAT cycles of latency, and tracks in-flight nonces in a tag pipe.
//   It reports the first (lowest) matching nonce, or exhaustion at NONCE_MAX.
//
// Optional feature macro: HASH_SEARCH_ABORT_EN
//   When defined, it adds the `abort` input, which ends an ISSUE/DRAIN search early
//   with res_found=0, res_nonce=last issued nonce and res_hash=0.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   job_valid/job_ready   job handshake; job_bloque (96b), job_target (8b)
//   core_bloque           latched block to the core
//   core_nonce/core_issue nonce to the core; core_issue marks a live issue
//   core_hash             core result, CORE_LAT cycles after the issue
//   abort                 (HASH_SEARCH_ABORT_EN only) stop the running search
//   res_valid/res_ready   result handshake; res_found, res_nonce, res_hash
//   busy                  high while issuing or draining
module hash_search_ctrl #(
    parameter int unsigned CORE_LAT  = 1,
    parameter logic [31:0] NONCE_MAX = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [95:0] job_bloque,
    input  logic [7:0]  job_target,
    output logic [95:0] core_bloque,
    output logic [31:0] core_nonce,
    output logic        core_issue,
    input  logic [23:0] core_hash,
`ifdef HASH_SEARCH_ABORT_EN
    input  logic        abort,
`endif
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_found,
    output logic [31:0] res_nonce,
    output logic [23:0] res_hash,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  target_q, target_d;
    logic [95:0] bloque_q, bloque_d;
    logic        ready_q;
    logic        found_q, found_d;
    logic [31:0] rnonce_q, rnonce_d;
    logic [23:0] rhash_q, rhash_d;

    // Tag pipe: stage CORE_LAT-1 lines up with the core_hash of that nonce.
    logic [CORE_LAT-1:0]       tag_valid_q, tag_valid_d;
    logic [CORE_LAT-1:0][31:0] tag_nonce_q, tag_nonce_d;

    logic        tag_out_valid;
    logic [31:0] tag_out_nonce;
    logic        hit;
    logic        pipe_busy;
    logic        flush;
    logic        abort_req;
    logic        unused_hash_lo;

`ifdef HASH_SEARCH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The low hash byte does not take part in the match test.
    assign unused_hash_lo = ^core_hash[7:0];

    assign tag_out_valid = tag_valid_q[CORE_LAT-1];
    assign tag_out_nonce = tag_nonce_q[CORE_LAT-1];
    assign hit = tag_out_valid && (core_hash[23:16] < target_q) && (core_hash[15:8] < target_q);

    // A valid tag anywhere before the output stage means results are still due.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(CORE_LAT) - 1; i++) begin
            pipe_busy = pipe_busy | tag_valid_q[i];
        end
    end

    assign job_ready   = ready_q;
    assign core_bloque = bloque_q;
    assign core_nonce  = cnt_q;
    assign core_issue  = (state_q == ST_ISSUE);
    assign res_valid   = (state_q == ST_DONE);
    assign res_found   = found_q;
    assign res_nonce   = rnonce_q;
    assign res_hash    = rhash_q;
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        bloque_d = bloque_q;
        found_d  = found_q;
        rnonce_d = rnonce_q;
        rhash_d  = rhash_q;
        flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (job_valid && ready_q) begin
                    state_d  = ST_ISSUE;
                    cnt_d    = 32'd0;
                    target_d = job_target;
                    bloque_d = job_bloque;
                end
            end
            ST_ISSUE: begin
                // The counter parks at NONCE_MAX so it never wraps.
                if (cnt_q == NONCE_MAX) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                // The last tag (NONCE_MAX) is at the output this cycle.
                if (!pipe_busy) begin
                    state_d  = ST_DONE;
                    found_d  = 1'b0;
                    rnonce_d = NONCE_MAX;
                    rhash_d  = tag_out_valid ? core_hash : 24'h0;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A match outranks both exhaustion and abort in the same cycle.
        if ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) begin
            if (hit) begin
                state_d  = ST_DONE;
                found_d  = 1'b1;
                rnonce_d = tag_out_nonce;
                rhash_d  = core_hash;
                flush    = 1'b1;
            end else if (abort_req) begin
                state_d  = ST_DONE;
                found_d  = 1'b0;
                rnonce_d = cnt_q;
                rhash_d  = 24'h0;
                flush    = 1'b1;
            end
        end
    end

    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_nonce_d    = tag_nonce_q;
        tag_valid_d[0] = core_issue;
        tag_nonce_d[0] = cnt_q;
        for (int i = 1; i < int'(CORE_LAT); i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_nonce_d[i] = tag_nonce_q[i-1];
        end
        if (flush) begin
            tag_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            target_q    <= 8'd0;
            bloque_q    <= 96'd0;
            ready_q     <= 1'b0;
            found_q     <= 1'b0;
            rnonce_q    <= 32'd0;
            rhash_q     <= 24'd0;
            tag_valid_q <= '0;
            tag_nonce_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            bloque_q    <= bloque_d;
            ready_q     <= (state_d == ST_IDLE);
            found_q     <= found_d;
            rnonce_q    <= rnonce_d;
            rhash_q     <= rhash_d;
            tag_valid_q <= tag_valid_d;
            tag_nonce_q <= tag_nonce_d;
        end
    end

endmodule
